// File: rtl/conv_pkg.sv
// Shared constants for the 64x64 3x3 convolution subsystem: scheduler state
// encoding, image geometry and the default watchdog limit.
package conv_pkg;

    localparam int IMG_DIM         = 64;
    localparam int IMG_PIXELS      = IMG_DIM * IMG_DIM;
    localparam int TIMEOUT_DEFAULT = 50000;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_HOST   = 3'd1;
    localparam logic [STATE_W-1:0] S_LAUNCH = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN    = 3'd3;
    localparam logic [STATE_W-1:0] S_GAP    = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd5;
    localparam logic [STATE_W-1:0] S_ERROR  = 3'd6;
    localparam logic [STATE_W-1:0] S_ABORT  = 3'd7;

endpackage

// File: rtl/conv_watchdog.sv
// Saturating cycle counter with synchronous clear; flags the cycle in which an
// enabled increment would land on TIMEOUT-1.
module conv_watchdog #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looking at the next count lets the scheduler leave RUN on the same edge.
    assign expire_o = en_i && (cnt_d == LAST);

endmodule

// File: rtl/conv_layer_scheduler.sv
// Multi-layer sequencer for the convolution controller: one pass per layer,
// ping-pong opcode toggling, watchdog guard and host RAM arbitration.
module conv_layer_scheduler
    import conv_pkg::*;
#(
    parameter int LAYER_W = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [LAYER_W-1:0] i_numLayers,
    input  logic               i_opcodeInit,
    input  logic               i_abort,
    input  logic               i_clear,
    input  logic               i_hostReq,
    input  logic               i_convFinish,
    output logic               o_convStart,
    output logic               o_convResetN,
    output logic               o_opcode,
    output logic [LAYER_W-1:0] o_layerIdx,
    output logic               o_hostGnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LAYER_W-1:0] numLayers_q, numLayers_d;
    logic [LAYER_W-1:0] layerIdx_q, layerIdx_d;
    logic               opcode_q, opcode_d;
    logic               resume_q, resume_d;
    logic               errEntry_q, errEntry_d;
    logic               wdExpire;
    logic               abortable;

    conv_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clear_i  (state_q == S_LAUNCH),
        .en_i     (state_q == S_RUN),
        .expire_o (wdExpire)
    );

    always_comb begin
        state_d     = state_q;
        numLayers_d = numLayers_q;
        layerIdx_d  = layerIdx_q;
        opcode_d    = opcode_q;
        resume_d    = resume_q;
        // A host-only visit from IDLE is not part of a run, so it cannot be aborted.
        abortable   = (state_q == S_LAUNCH) || (state_q == S_RUN) ||
                      (state_q == S_GAP) || ((state_q == S_HOST) && resume_q);

        if (i_abort && abortable) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        numLayers_d = i_numLayers;
                        if (i_numLayers != '0) begin
                            opcode_d   = i_opcodeInit;
                            layerIdx_d = '0;
                            state_d    = S_LAUNCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (i_hostReq) begin
                        resume_d = 1'b0;
                        state_d  = S_HOST;
                    end
                end
                S_HOST: begin
                    if (!i_hostReq) begin
                        state_d = resume_q ? S_LAUNCH : S_IDLE;
                    end
                end
                S_LAUNCH: state_d = S_RUN;
                S_RUN: begin
                    if (i_convFinish) begin
                        if (layerIdx_q == (numLayers_q - 1'b1)) begin
                            state_d = S_DONE;
                        end else begin
                            layerIdx_d = layerIdx_q + 1'b1;
                            opcode_d   = ~opcode_q;
                            state_d    = S_GAP;
                        end
                    end else if (wdExpire) begin
                        state_d = S_ERROR;
                    end
                end
                S_GAP: begin
                    if (i_hostReq) begin
                        resume_d = 1'b1;
                        state_d  = S_HOST;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERROR: begin
                    if (i_clear) begin
                        state_d = S_IDLE;
                    end
                end
                S_ABORT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        errEntry_d = (state_d == S_ERROR) && (state_q != S_ERROR);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            numLayers_q <= '0;
            layerIdx_q  <= '0;
            opcode_q    <= 1'b0;
            resume_q    <= 1'b0;
            errEntry_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            numLayers_q <= numLayers_d;
            layerIdx_q  <= layerIdx_d;
            opcode_q    <= opcode_d;
            resume_q    <= resume_d;
            errEntry_q  <= errEntry_d;
        end
    end

    assign o_convStart  = (state_q == S_LAUNCH);
    assign o_convResetN = !((state_q == S_ABORT) || errEntry_q);
    assign o_opcode     = opcode_q;
    assign o_layerIdx   = layerIdx_q;
    assign o_hostGnt    = (state_q == S_HOST);
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign o_done       = (state_q == S_DONE);
    assign o_error      = (state_q == S_ERROR);

endmodule
